// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;
  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;
  localparam int WCW = 3;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational two-way round-robin pick with optional owner lock
//   req0, req1 : pending requests
//   last       : last-granted master index
//   lock       : regrant last owner if it is still requesting
//   gnt        : winning master index; gnt_valid : any request present
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic lock,
  output logic gnt,
  output logic gnt_valid
);
  logic keep;
  always_comb begin
    keep = lock && (last ? req1 : req0);
    gnt_valid = req0 | req1;
    gnt = keep ? last : (req0 && req1) ? ~last : (req1 ? M_DMA : M_CPU);
  end
endmodule

// File: rtl/mem_arbiter16.sv
// mem_arbiter16: round-robin arbiter sharing one RAM port between two masters
//   clk, reset (async, active-low)
//   m0_*/m1_*  : req/addr/we/wdata in, ack pulse and held rdata out
//   ram_*      : RAM address, one-cycle write strobe, write data, read data
//   owner      : granted or last-granted master; bus_busy : transaction in flight
//   MEM_ARBITER_LOCK_EN adds m0_lock/m1_lock for atomic back-to-back regrant
module mem_arbiter16
  import mem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int RAM_WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
`ifdef MEM_ARBITER_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          owner,
  output logic          bus_busy
);
  state_t state, state_nx;
  logic [WCW-1:0] wcnt;
  logic lat_we, gnt, gnt_valid, lock_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  arb_rr_pick u_pick (
    .req0(m0_req),
    .req1(m1_req),
    .last(owner),
    .lock(lock_q),
    .gnt(gnt),
    .gnt_valid(gnt_valid)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = gnt_valid ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nx = (lat_we || RAM_WAIT == 0) ? S_ACK : S_WAIT;
      S_WAIT:  state_nx = (wcnt == '0) ? S_ACK : S_WAIT;
      default: state_nx = S_IDLE;
    endcase
  end

  // ram_addr/ram_wdata double as the transaction latch, so they hold after issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      owner <= M_DMA;
      wcnt <= '0;
      lat_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && gnt_valid) begin
        owner <= gnt;
        ram_addr <= gnt ? m1_addr : m0_addr;
        ram_wdata <= gnt ? m1_wdata : m0_wdata;
        lat_we <= gnt ? m1_we : m0_we;
      end
      if (state == S_ISSUE && !lat_we && RAM_WAIT != 0)
        wcnt <= WCW'(RAM_WAIT - 1);
      else if (state == S_WAIT && wcnt != '0)
        wcnt <= wcnt - 1'b1;
      if (state == S_ACK && !lat_we && owner == M_CPU)
        rdata0_q <= ram_rdata;
      if (state == S_ACK && !lat_we && owner == M_DMA)
        rdata1_q <= ram_rdata;
    end
  end

`ifdef MEM_ARBITER_LOCK_EN
  // lock is sampled at ack and only honoured in the immediately following idle cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lock_q <= 1'b0;
    else
      lock_q <= (state == S_ACK) ? (owner ? m1_lock : m0_lock) : 1'b0;
  end
`else
  assign lock_q = 1'b0;
`endif

  assign ram_we = (state == S_ISSUE) && lat_we;
  assign bus_busy = state != S_IDLE;
  assign m0_ack = (state == S_ACK) && owner == M_CPU;
  assign m1_ack = (state == S_ACK) && owner == M_DMA;
  // read data is forwarded in the ack cycle and held in the register afterwards
  assign m0_rdata = (m0_ack && !lat_we) ? ram_rdata : rdata0_q;
  assign m1_rdata = (m1_ack && !lat_we) ? ram_rdata : rdata1_q;
endmodule

// File: tb/tb_mem_arbiter16.sv
// tb_mem_arbiter16: scoreboard bench for mem_arbiter16 (RAM_WAIT=1)
module tb_mem_arbiter16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic m0_ack, m1_ack, ram_we, owner, bus_busy;
  logic [15:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
`ifdef MEM_ARBITER_LOCK_EN
  logic m0_lock = 1'b0, m1_lock = 1'b0;
`endif

  typedef struct {
    logic m;
    logic [15:0] d;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter16 #(.AW(16), .DW(16), .RAM_WAIT(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef MEM_ARBITER_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner), .bus_busy(bus_busy)
  );

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic m, input logic [15:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && (m0_ack || m1_ack)) begin
      if (m0_ack && m1_ack) chk("double_ack", 1, 0);
      else if (q.size() == 0) chk("unexpected_ack", {31'd0, m1_ack}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_master", {31'd0, m1_ack}, {31'd0, e.m});
        chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.d);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // waits for master m's ack, counting cycles and RAM write strobes seen
  task automatic wait_ack(input logic m, output int lat, output int wes,
                          output logic [15:0] wa, output logic [15:0] wd);
    lat = 0;
    wes = 0;
    wa = 'x;
    wd = 'x;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (ram_we) begin
        wes++;
        wa = ram_addr;
        wd = ram_wdata;
      end
      if (m ? m1_ack : m0_ack) return;
    end
    chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_any(output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m0_ack || m1_ack) begin
        at = cyc;
        return;
      end
    end
    chk("any_ack_timeout", 0, 1);
  endtask

  initial begin
    int lat, wes, t, prev;
    logic [15:0] wa, wd;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h4000] = 16'hBEEF;
    mem[16'h0080] = 16'h0055;
    repeat (2) @(negedge clk);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    tick();
    reset = 1'b1;
    tick();
    // single read: ack 3 cycles after the request is sampled
    m0_addr = 16'h4000;
    m0_we = 1'b0;
    m0_req = 1'b1;
    push(0, 16'hBEEF);
    tick();
    chk("rd_issue_addr", ram_addr, 16'h4000);
    chk("rd_issue_we", ram_we, 0);
    chk("rd_issue_busy", bus_busy, 1);
    chk("rd_owner", owner, 0);
    wait_ack(0, lat, wes, wa, wd);
    chk("rd_latency", lat, 2);
    m0_req = 1'b0;
    tick();
    tick();
    chk("rd_rdata_held", m0_rdata, 16'hBEEF);
    chk("rd_idle_busy", bus_busy, 0);
    chk("rd_addr_held", ram_addr, 16'h4000);
    // single write by master 1
    m1_addr = 16'h00F0;
    m1_we = 1'b1;
    m1_wdata = 16'h1234;
    m1_req = 1'b1;
    push(1, 16'h0000);
    wait_ack(1, lat, wes, wa, wd);
    chk("wr_latency", lat, 2);
    chk("wr_we_cycles", wes, 1);
    chk("wr_addr", wa, 16'h00F0);
    chk("wr_wdata", wd, 16'h1234);
    m1_req = 1'b0;
    tick();
    chk("wr_mem", mem[16'h00F0], 16'h1234);
    chk("wr_rdata_unchanged", m1_rdata, 0);
    chk("wr_we_low", ram_we, 0);
    // contention: continuous requests alternate, acks 4 cycles apart
    m1_we = 1'b0;
    for (int k = 0; k < 6; k++) push(k[0], k[0] ? 16'h1234 : 16'hBEEF);
    m0_req = 1'b1;
    m1_req = 1'b1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_any(t);
      chk("cont_order", {31'd0, m1_ack}, {31'd0, k[0]});
      if (k > 0) chk("cont_spacing", t - prev, 4);
      prev = t;
      if (k == 5) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    repeat (3) tick();
    chk("cont_m1_rdata", m1_rdata, 16'h1234);
    // request withdrawn during the wait state still completes once
    m0_req = 1'b1;
    push(0, 16'hBEEF);
    tick();
    tick();
    m0_req = 1'b0;
    tick();
    chk("drop_ack", m0_ack, 1);
    repeat (4) tick();
    // reset during the wait state: transaction lost, no ack
    m1_req = 1'b1;
    tick();
    tick();
    chk("rst_mid_busy_before", bus_busy, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_we", ram_we, 0);
    chk("rst_mid_acks", {m0_ack, m1_ack}, 0);
    chk("rst_mid_owner", owner, 1);
    chk("rst_mid_busy", bus_busy, 0);
    chk("rst_mid_rdata", {m0_rdata, m1_rdata}, 0);
    m1_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    // after reset the first tie goes to master 0
    push(0, 16'hBEEF);
    push(1, 16'h1234);
    m0_req = 1'b1;
    m1_req = 1'b1;
    wait_any(t);
    chk("tie_after_rst", {31'd0, m0_ack}, 1);
    m0_req = 1'b0;
    wait_ack(1, lat, wes, wa, wd);
    m1_req = 1'b0;
    repeat (2) tick();
`ifdef MEM_ARBITER_LOCK_EN
    // locked read-modify-write by master 1 is not split by master 0
    m1_addr = 16'h0080;
    m1_we = 1'b0;
    m1_lock = 1'b1;
    m1_req = 1'b1;
    push(1, 16'h0055);
    push(1, 16'h0055);
    push(0, 16'hBEEF);
    tick();
    m0_req = 1'b1;
    wait_ack(1, lat, wes, wa, wd);
    m1_we = 1'b1;
    m1_wdata = 16'h0056;
    wait_ack(1, lat, wes, wa, wd);
    chk("lock_wr_addr", wa, 16'h0080);
    m1_req = 1'b0;
    m1_lock = 1'b0;
    wait_ack(0, lat, wes, wa, wd);
    m0_req = 1'b0;
    tick();
    chk("lock_mem", mem[16'h0080], 16'h0056);
    repeat (2) tick();
`endif
    repeat (3) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter16.md
# mem_arbiter16

Two-master memory arbiter for the 16-bit system bus. Shares the single RAM port between master 0 (CPU16 core) and master 1 (DMA or video fetch engine) using round-robin arbitration, one transaction at a time. Each transaction is issued to RAM with a configurable wait-state count. Each transaction is acknowledged to its master with read data. The arbiter sits between the masters and the RAM/IO decode.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- RAM_WAIT, 1, RAM read wait cycles after address issue (0..7)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_addr  in  AW  master 0 address; stable while m0_req
- m0_we  in  1  master 0 write enable; stable while m0_req
- m0_wdata  in  DW  master 0 write data
- m0_ack  out  1  one-cycle completion pulse to master 0
- m0_rdata  out  DW  read data; valid in the m0_ack cycle, held after
- m1_req, m1_addr, m1_we, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data
- owner  out  1  index of the granted or last-granted master
- bus_busy  out  1  high from ISSUE through ACK

## Operation
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_ACK.
- S_IDLE: a requester is sampled.
  - If one requester is present, it wins.
  - If both are present, the master that is not `owner` wins (round-robin).
  - The winner's addr, we and wdata are latched, `owner` is updated, and the FSM moves to S_ISSUE.
  - With no request, the FSM stays in S_IDLE.
- S_ISSUE: ram_addr and ram_wdata are driven from the latch.
  - ram_we = latched we, for exactly this one cycle.
  - Write: go to S_ACK.
  - Read with RAM_WAIT=0: go to S_ACK.
  - Read with RAM_WAIT>0: go to S_WAIT and load the wait counter with RAM_WAIT-1.
- S_WAIT: the counter decrements each cycle; the FSM goes to S_ACK when the counter reaches 0.
- S_ACK: the owner's ack pulses high.
  - On a read, ram_rdata is captured into the owner's rdata register.
  - On a write, rdata is unchanged.
  - The FSM returns to S_IDLE.
- ram_addr holds its last value outside S_ISSUE. ram_we is 0 in every state except S_ISSUE.
- Request rules:
  - A req that deasserts before ack does not abort the transaction; ack still pulses.
  - A master must deassert req, or present a new request, in the cycle after ack. A req still high in S_IDLE is treated as a new request.
- Reset values:
  - Outputs: m0_ack, m1_ack, ram_we, bus_busy = 0; ram_addr, ram_wdata, m0_rdata, m1_rdata = 0; owner = 1, so master 0 wins the first tie.
  - Internal: FSM = S_IDLE, wait counter = 0.

## Timing
- Request sampled in S_IDLE at cycle T: ram_we/ram_addr at T+1, ack at T+2 (write) or T+2+RAM_WAIT (read).
- Back-to-back transactions: next S_IDLE at T+3 (write), so minimum issue spacing is 3+RAM_WAIT cycles for reads.
- Contention: with both masters requesting continuously, grants strictly alternate.
- Reset asserted mid-transaction: ram_we and ack drop to 0 immediately (asynchronous). The transaction is lost and not acked; masters reissue after reset.
- RAM_WAIT=0: S_WAIT is never entered.

## Configuration
- MEM_ARBITER_LOCK_EN: when defined, adds input ports m0_lock and m1_lock (1 bit each).
  - If the owner's lock is high in S_ACK and its req is high in the next S_IDLE, it is regranted regardless of round-robin. This provides atomic read-modify-write.
  - The lock is ignored if the owner's req is low.
- When undefined: no lock ports; pure round-robin.

## Structure
- Package mem_arb_pkg:
  - state enum (S_IDLE, S_ISSUE, S_WAIT, S_ACK)
  - master index constants M_CPU=0, M_DMA=1
  - wait counter width constant (3 bits)
- Sub-module arb_rr_pick (combinational): inputs req0, req1, last owner, and optional lock; outputs grant index and grant valid. Instantiated once.
- The FSM, latches and wait counter live in mem_arbiter16.

## Test plan
- Single read, RAM_WAIT=1: m0 reads 0x4000 with RAM returning 0xBEEF → ram_addr=0x4000 at T+1, m0_ack and m0_rdata=0xBEEF at T+3.
- Single write: m1 writes 0x1234 to 0x00F0 → ram_we high for one cycle with ram_addr=0x00F0 and ram_wdata=0x1234; m1_ack at T+2; m1_rdata unchanged.
- Contention: both masters request reads continuously for 6 transactions → grant order 0,1,0,1,0,1; no double ack; acks spaced 4 cycles apart.
- Req dropped early: m0_req falls in the S_WAIT cycle → the transaction still completes and m0_ack pulses once.
- Reset mid-read: reset asserted during S_WAIT → ram_we=0, acks=0, owner=1, FSM idle; the next tie is won by master 0.
- Lock (MEM_ARBITER_LOCK_EN): m1 locks a read followed by a write to the same address while m0 also requests → m1 is granted both before m0.
